preview_fifo_wr_arb: RTL and testbench

//  Two-source write arbiter/scheduler for the preview_fifo 2-word write port.

---
 rtl/preview_fifo_wr_arb.sv | 136 +++++++++++++
 tb/tb_preview_fifo_wr_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preview_fifo_wr_arb.sv
// preview_fifo_wr_arb: two-source round-robin write scheduler for the preview_fifo 2-word write port.
// Latency: offer acked combinationally in cycle N, appears on registered wrreq/id0/id1 in cycle N+1.
// Backpressure: an offer is acked only when it fits whole in the space left after usedw and in-flight words.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s0_cnt/d0/d1/ack         source 0 offer (0/1/2 words, 3 treated as none), held until s0_ack
//   s1_cnt/d0/d1/ack         source 1 offer, same encoding
//   wrreq, id0, id1          registered one-hot write request and data to preview_fifo
//   full, usedw              status from preview_fifo
module preview_fifo_wr_arb #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int USED_W = $clog2(DEPTH),
  parameter bit MERGE  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        s0_cnt,
  input  logic [WIDTH-1:0]  s0_d0,
  input  logic [WIDTH-1:0]  s0_d1,
  output logic              s0_ack,
  input  logic [1:0]        s1_cnt,
  input  logic [WIDTH-1:0]  s1_d0,
  input  logic [WIDTH-1:0]  s1_d1,
  output logic              s1_ack,
  output logic [2:0]        wrreq,
  output logic [WIDTH-1:0]  id0,
  output logic [WIDTH-1:0]  id1,
  input  logic [1:0]        full,
  input  logic [USED_W-1:0] usedw
);

  localparam logic [2:0] WR_NONE = 3'b001;
  localparam logic [2:0] WR_ONE  = 3'b010;
  localparam logic [2:0] WR_TWO  = 3'b100;

  localparam int              LIMIT_I = DEPTH - 2;
  localparam int              TWO_I   = 2;
  localparam logic [USED_W:0] LIMIT   = LIMIT_I[USED_W:0];
  localparam logic [USED_W:0] TWO_W   = TWO_I[USED_W:0];

  logic [2:0]       r_wrreq;
  logic [WIDTH-1:0] r_id0;
  logic [WIDTH-1:0] r_id1;
  logic             r_rr;

  logic [1:0]       w_inflight;
  logic [USED_W:0]  w_need;
  logic [USED_W:0]  w_avail;
  logic [1:0]       w_cnt0, w_cnt1;
  logic [1:0]       w_cp, w_cq;
  logic [WIDTH-1:0] w_dp0, w_dp1, w_dq0, w_dq1;
  logic             w_fit_p, w_fit_q, w_merge;
  logic             w_ack_p, w_ack_q;
  logic [2:0]       w_wrreq_nx;
  logic [WIDTH-1:0] w_id0_nx, w_id1_nx;
  logic             w_rr_nx;

  // Words already committed to the bus but not yet reflected in usedw.
  always_comb begin
    w_inflight = 2'd0;
    if (r_wrreq == WR_ONE) w_inflight = 2'd1;
    if (r_wrreq == WR_TWO) w_inflight = 2'd2;
  end

  // One bit wider than usedw so the subtraction clamps instead of wrapping.
  assign w_need  = {1'b0, usedw} + {{(USED_W-1){1'b0}}, w_inflight};
  assign w_avail = (w_need >= LIMIT) ? '0 : (LIMIT - w_need);

  assign w_cnt0 = (s0_cnt == 2'd3) ? 2'd0 : s0_cnt;
  assign w_cnt1 = (s1_cnt == 2'd3) ? 2'd0 : s1_cnt;

  // p is the current round-robin priority source, q the other one.
  assign w_cp  = r_rr ? w_cnt1 : w_cnt0;
  assign w_cq  = r_rr ? w_cnt0 : w_cnt1;
  assign w_dp0 = r_rr ? s1_d0  : s0_d0;
  assign w_dp1 = r_rr ? s1_d1  : s0_d1;
  assign w_dq0 = r_rr ? s0_d0  : s1_d0;
  assign w_dq1 = r_rr ? s0_d1  : s1_d1;

  assign w_fit_p = (w_cp != 2'd0) && ({{(USED_W-1){1'b0}}, w_cp} <= w_avail) && (full == 2'b00);
  assign w_fit_q = (w_cq != 2'd0) && ({{(USED_W-1){1'b0}}, w_cq} <= w_avail) && (full == 2'b00);
  assign w_merge = MERGE && (w_cp == 2'd1) && (w_cq == 2'd1) && (w_avail >= TWO_W) && (full == 2'b00);

  always_comb begin
    w_ack_p    = 1'b0;
    w_ack_q    = 1'b0;
    w_wrreq_nx = WR_NONE;
    w_id0_nx   = r_id0;
    w_id1_nx   = r_id1;
    w_rr_nx    = r_rr;
    if (w_merge) begin
      w_ack_p    = 1'b1;
      w_ack_q    = 1'b1;
      w_wrreq_nx = WR_TWO;
      w_id0_nx   = w_dp0;
      w_id1_nx   = w_dq0;
      w_rr_nx    = ~r_rr;
    end else if (w_fit_p) begin
      w_ack_p    = 1'b1;
      w_wrreq_nx = (w_cp == 2'd2) ? WR_TWO : WR_ONE;
      w_id0_nx   = w_dp0;
      w_id1_nx   = (w_cp == 2'd2) ? w_dp1 : '0;
      w_rr_nx    = ~r_rr;
    end else if (w_fit_q) begin
      // Winner is q, so the pointer moves to p: p keeps priority next cycle.
      w_ack_q    = 1'b1;
      w_wrreq_nx = (w_cq == 2'd2) ? WR_TWO : WR_ONE;
      w_id0_nx   = w_dq0;
      w_id1_nx   = (w_cq == 2'd2) ? w_dq1 : '0;
      w_rr_nx    = r_rr;
    end
  end

  assign s0_ack = ~rst & (r_rr ? w_ack_q : w_ack_p);
  assign s1_ack = ~rst & (r_rr ? w_ack_p : w_ack_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrreq <= WR_NONE;
      r_id0   <= '0;
      r_id1   <= '0;
      r_rr    <= 1'b0;
    end else begin
      r_wrreq <= w_wrreq_nx;
      r_id0   <= w_id0_nx;
      r_id1   <= w_id1_nx;
      r_rr    <= w_rr_nx;
    end
  end

  assign wrreq = r_wrreq;
  assign id0   = r_id0;
  assign id1   = r_id1;

endmodule

// File: tb/tb_preview_fifo_wr_arb.sv
module tb_preview_fifo_wr_arb;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 16;
  localparam int USED_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       cnt [2];
  logic [WIDTH-1:0] d0 [2];
  logic [WIDTH-1:0] d1 [2];
  logic [1:0]       full;
  logic [USED_W-1:0] usedw;
  logic             s0_ack, s1_ack;
  logic [2:0]       wrreq;
  logic [WIDTH-1:0] id0, id1;

  int errors = 0;
  int checks = 0;

  // reference model state
  int         m_rr, m_inflight;
  logic [2:0] m_wrreq;
  logic [31:0] m_id0, m_id1;
  // model prediction for the current cycle
  logic       e_ack [2];
  logic [2:0] e_wrreq;
  logic [31:0] e_id0, e_id1;
  int         e_rr;
  // acks sampled mid-cycle
  logic       o_ack [2];
  // data tagging for the scoreboard
  int gen_seq [2];

  preview_fifo_wr_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .USED_W(USED_W), .MERGE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .s0_cnt(cnt[0]), .s0_d0(d0[0]), .s0_d1(d1[0]), .s0_ack(s0_ack),
    .s1_cnt(cnt[1]), .s1_d0(d0[1]), .s1_d1(d1[1]), .s1_ack(s1_ack),
    .wrreq(wrreq), .id0(id0), .id1(id1), .full(full), .usedw(usedw)
  );

  function automatic logic [31:0] tag(int s, int q);
    logic [31:0] sv, qv;
    sv = s;
    qv = q;
    return {sv[3:0], qv[27:0]};
  endfunction

  task automatic load(int s, int c);
    cnt[s] = c[1:0];
    d0[s]  = tag(s, gen_seq[s]);
    d1[s]  = tag(s, gen_seq[s] + 1);
    gen_seq[s] += c;
  endtask

  task automatic model_reset();
    m_rr = 0; m_inflight = 0; m_wrreq = 3'b001; m_id0 = '0; m_id1 = '0;
  endtask

  // Scheduling rules stated directly in words-of-space arithmetic.
  task automatic predict();
    int c [2];
    int av, p, q, w;
    for (int s = 0; s < 2; s++) c[s] = (cnt[s] == 2'd3) ? 0 : int'(cnt[s]);
    av = (DEPTH - 2) - int'(usedw) - m_inflight;
    if (av < 0) av = 0;
    if (full != 2'b00) av = 0;
    p = m_rr; q = 1 - m_rr;
    e_ack[0] = 1'b0; e_ack[1] = 1'b0;
    e_wrreq = 3'b001; e_id0 = m_id0; e_id1 = m_id1; e_rr = m_rr;
    w = -1;
    if (c[0] == 1 && c[1] == 1 && av >= 2) begin
      e_ack[0] = 1'b1; e_ack[1] = 1'b1;
      e_wrreq = 3'b100; e_id0 = d0[p]; e_id1 = d0[q]; e_rr = 1 - m_rr;
    end else if (c[p] != 0 && c[p] <= av) w = p;
    else if (c[q] != 0 && c[q] <= av) w = q;
    if (w >= 0) begin
      e_ack[w] = 1'b1;
      e_wrreq = (c[w] == 2) ? 3'b100 : 3'b010;
      e_id0 = d0[w];
      e_id1 = (c[w] == 2) ? d1[w] : '0;
      e_rr = 1 - w;
    end
  endtask

  // One clock: inputs already set; sample acks at negedge, outputs 1ns after posedge.
  task automatic cycle();
    predict();
    @(negedge clk);
    o_ack[0] = s0_ack; o_ack[1] = s1_ack;
    @(posedge clk); #1;
    m_rr = e_rr; m_wrreq = e_wrreq; m_id0 = e_id0; m_id1 = e_id1;
    m_inflight = (e_wrreq == 3'b010) ? 1 : (e_wrreq == 3'b100) ? 2 : 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; full = 2'b00; usedw = '0;
    cnt[1] = 2'd0; d0[1] = '0; d1[1] = '0;
    cnt[0] = 2'd2; d0[0] = 32'hA1A1_0001; d1[0] = 32'hA2A2_0002;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wrreq !== 3'b001 || id0 !== '0 || id1 !== '0) begin
      errors++; $display("FAIL reset_outputs got wrreq=%b id0=%h id1=%h exp 001/0/0", wrreq, id0, id1);
    end
    checks++;
    if (s0_ack !== 1'b0 || s1_ack !== 1'b0) begin
      errors++; $display("FAIL reset_acks got %b%b exp 00", s0_ack, s1_ack);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();
    checks++;
    if (o_ack[0] !== 1'b1 || o_ack[1] !== 1'b0) begin
      errors++; $display("FAIL reset_first_ack got %b%b exp 10", o_ack[0], o_ack[1]);
    end
    checks++;
    if (wrreq !== 3'b100 || id0 !== 32'hA1A1_0001 || id1 !== 32'hA2A2_0002) begin
      errors++; $display("FAIL reset_first_write got %b %h %h exp 100 a1a10001 a2a20002", wrreq, id0, id1);
    end
    cnt[0] = 2'd0;
  endtask

  task automatic test_back_to_back();
    int start;
    usedw = '0; full = 2'b00;
    load(0, 2); load(1, 2);
    start = m_rr;
    for (int i = 0; i < 6; i++) begin
      int w;
      w = (start + i) % 2;
      cycle();
      checks++;
      if (o_ack[w] !== 1'b1 || o_ack[1-w] !== 1'b0) begin
        errors++; $display("FAIL b2b_ack[%0d] got %b%b exp winner s%0d", i, o_ack[0], o_ack[1], w);
      end
      checks++;
      if (wrreq !== 3'b100 || id0 !== d0[w] || id1 !== d1[w]) begin
        errors++; $display("FAIL b2b_write[%0d] got %b %h %h exp 100 %h %h", i, wrreq, id0, id1, d0[w], d1[w]);
      end
      load(w, 2);
    end
    cnt[0] = 2'd0; cnt[1] = 2'd0;
  endtask

  task automatic test_merge();
    usedw = '0; full = 2'b00;
    cnt[0] = 2'd0; cnt[1] = 2'd0;
    if (m_rr == 0) begin
      load(0, 1); cycle(); cnt[0] = 2'd0;
    end
    cnt[0] = 2'd1; d0[0] = 32'hAAAA_0001;
    cnt[1] = 2'd1; d0[1] = 32'hBBBB_0002;
    cycle();
    checks++;
    if (o_ack[0] !== 1'b1 || o_ack[1] !== 1'b1) begin
      errors++; $display("FAIL merge_acks got %b%b exp 11", o_ack[0], o_ack[1]);
    end
    checks++;
    if (wrreq !== 3'b100 || id0 !== 32'hBBBB_0002 || id1 !== 32'hAAAA_0001) begin
      errors++; $display("FAIL merge_write got %b %h %h exp 100 bbbb0002 aaaa0001", wrreq, id0, id1);
    end
    cnt[0] = 2'd0; cnt[1] = 2'd0;
  endtask

  task automatic test_space();
    logic [31:0] s1w;
    usedw = '0; full = 2'b00;
    cnt[1] = 2'd0; load(0, 1); cycle();
    cnt[0] = 2'd0; load(1, 1); cycle();
    cnt[1] = 2'd0;
    // previous write is 1 word, rr back on s0
    usedw = 4'd12; load(0, 2); load(1, 1); s1w = d0[1];
    cycle();
    checks++;
    if (o_ack[0] !== 1'b0 || o_ack[1] !== 1'b1) begin
      errors++; $display("FAIL space_ack got %b%b exp 01", o_ack[0], o_ack[1]);
    end
    checks++;
    if (wrreq !== 3'b010 || id0 !== s1w || id1 !== '0) begin
      errors++; $display("FAIL space_write got %b %h %h exp 010 %h 0", wrreq, id0, id1, s1w);
    end
    usedw = 4'd13; load(1, 1);
    cycle();
    checks++;
    if (o_ack[0] !== 1'b0 || o_ack[1] !== 1'b0 || wrreq !== 3'b001) begin
      errors++; $display("FAIL space_none got ack=%b%b wrreq=%b exp 00 001", o_ack[0], o_ack[1], wrreq);
    end
    checks++;
    if (id0 !== s1w || id1 !== '0) begin
      errors++; $display("FAIL space_hold got %h %h exp %h 0", id0, id1, s1w);
    end
    usedw = '0;
    cycle();
    checks++;
    if (o_ack[0] !== 1'b1 || wrreq !== 3'b100 || id0 !== d0[0]) begin
      errors++; $display("FAIL space_resume got ack0=%b %b %h exp 1 100 %h", o_ack[0], wrreq, id0, d0[0]);
    end
    cnt[0] = 2'd0; cnt[1] = 2'd0;
  endtask

  task automatic test_full();
    logic [1:0] fv [4];
    fv[0] = 2'b01; fv[1] = 2'b01; fv[2] = 2'b10; fv[3] = 2'b11;
    usedw = '0; load(0, 2); load(1, 1);
    for (int i = 0; i < 4; i++) begin
      full = fv[i];
      cycle();
      checks++;
      if (o_ack[0] !== 1'b0 || o_ack[1] !== 1'b0 || wrreq !== 3'b001) begin
        errors++; $display("FAIL full_block[%0d] got ack=%b%b wrreq=%b exp 00 001", i, o_ack[0], o_ack[1], wrreq);
      end
    end
    full = 2'b00;
    cycle();
    checks++;
    if (o_ack[0] !== e_ack[0] || o_ack[1] !== e_ack[1] || wrreq !== m_wrreq || id0 !== m_id0 || id1 !== m_id1) begin
      errors++; $display("FAIL full_release got ack=%b%b %b %h %h exp ack=%b%b %b %h %h",
                         o_ack[0], o_ack[1], wrreq, id0, id1, e_ack[0], e_ack[1], m_wrreq, m_id0, m_id1);
    end
    cnt[0] = 2'd0; cnt[1] = 2'd0;
  endtask

  task automatic test_illegal();
    usedw = '0; full = 2'b00;
    cnt[0] = 2'd3; d0[0] = 32'hDEAD_0000; d1[0] = 32'hDEAD_0001; cnt[1] = 2'd0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (o_ack[0] !== 1'b0 || o_ack[1] !== 1'b0 || wrreq !== 3'b001) begin
        errors++; $display("FAIL illegal_cnt[%0d] got ack=%b%b wrreq=%b exp 00 001", i, o_ack[0], o_ack[1], wrreq);
      end
      cnt[1] = 2'd3;
    end
    cnt[0] = 2'd0; cnt[1] = 2'd0;
  endtask

  task automatic test_reset_mid();
    usedw = '0; full = 2'b00;
    load(0, 2); load(1, 1);
    cycle();
    rst = 1'b1;
    #2;
    checks++;
    if (wrreq !== 3'b001 || id0 !== '0 || id1 !== '0 || s0_ack !== 1'b0 || s1_ack !== 1'b0) begin
      errors++; $display("FAIL reset_mid got wrreq=%b id0=%h id1=%h ack=%b%b exp 001 0 0 00", wrreq, id0, id1, s0_ack, s1_ack);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();
    checks++;
    if (o_ack[0] !== 1'b1 || o_ack[1] !== 1'b0 || wrreq !== 3'b100 || id0 !== d0[0]) begin
      errors++; $display("FAIL reset_mid_resume got ack=%b%b %b %h exp 10 100 %h", o_ack[0], o_ack[1], wrreq, id0, d0[0]);
    end
    cnt[0] = 2'd0; cnt[1] = 2'd0;
  endtask

  task automatic test_random();
    int pend [2];
    int acked [2];
    int exp_next [2];
    int r;
    for (int s = 0; s < 2; s++) begin
      pend[s] = 0; acked[s] = 0; exp_next[s] = 0; gen_seq[s] = 0; cnt[s] = 2'd0;
    end
    for (int n = 0; n < 500; n++) begin
      for (int s = 0; s < 2; s++) begin
        if (pend[s] == 0) begin
          r = $urandom_range(0, 5);
          if (r >= 2) begin
            load(s, (r >= 4) ? 2 : 1); pend[s] = 1;
          end else begin
            cnt[s] = (r == 1) ? 2'd3 : 2'd0; d0[s] = $urandom; d1[s] = $urandom;
          end
        end
      end
      usedw = ($urandom_range(0, 3) == 0) ? USED_W'($urandom_range(8, 15)) : USED_W'($urandom_range(0, 10));
      full  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle();
      checks++;
      if (o_ack[0] !== e_ack[0] || o_ack[1] !== e_ack[1]) begin
        errors++; $display("FAIL rand_ack[%0d] got %b%b exp %b%b", n, o_ack[0], o_ack[1], e_ack[0], e_ack[1]);
      end
      checks++;
      if (wrreq !== m_wrreq || id0 !== m_id0 || id1 !== m_id1) begin
        errors++; $display("FAIL rand_write[%0d] got %b %h %h exp %b %h %h", n, wrreq, id0, id1, m_wrreq, m_id0, m_id1);
      end
      for (int s = 0; s < 2; s++) begin
        if (o_ack[s] === 1'b1 && pend[s] != 0) begin
          acked[s] += int'(cnt[s]); pend[s] = 0;
        end
      end
      if (wrreq == 3'b010 || wrreq == 3'b100) begin
        logic [31:0] wv [2];
        int nw;
        wv[0] = id0; wv[1] = id1;
        nw = (wrreq == 3'b100) ? 2 : 1;
        for (int k = 0; k < nw; k++) begin
          int s;
          logic [31:0] ev;
          s = int'(wv[k][31:28]);
          checks++;
          if (s > 1) begin
            errors++; $display("FAIL sb_source[%0d] got word %h exp source 0/1", n, wv[k]);
          end else begin
            ev = tag(s, exp_next[s]);
            if (wv[k] !== ev) begin
              errors++; $display("FAIL sb_order[%0d] got %h exp %h", n, wv[k], ev);
            end
            exp_next[s]++;
          end
        end
      end
    end
    cnt[0] = 2'd0; cnt[1] = 2'd0;
    cycle();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (exp_next[s] != acked[s]) begin
        errors++; $display("FAIL sb_count s%0d written=%0d exp acked=%0d", s, exp_next[s], acked[s]);
      end
    end
  endtask

  initial begin
    gen_seq[0] = 0; gen_seq[1] = 0;
    test_reset();
    test_back_to_back();
    test_merge();
    test_space();
    test_full();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
